// File: rtl/key_debounce_filter_pkg.sv
// Shared constants, settle FSM state type and popcount helper for the
// key debounce/settle filter slice.
package key_debounce_filter_pkg;

   // Default key vector width (matches Pin_input downstream)
   localparam int unsigned KDF_KEYS          = 10;

   // Default timing at 100 MHz: 10 ms per-key debounce, 5 ms vector settle
   localparam int unsigned KDF_DB_CYCLES     = 1_000_000;
   localparam int unsigned KDF_SETTLE_CYCLES = 500_000;

   // Vector settle FSM states
   typedef enum logic {
      KDF_STABLE = 1'b0,
      KDF_SETTLE = 1'b1
   } kdf_state_t;

   // Number of set bits in a (zero-extended) key vector
   function automatic int unsigned kdf_popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key: 2-FF synchroniser into the clk domain followed by a hold-time
// debouncer. A new level is accepted only after it has differed from the
// accepted level for DB_CYCLES consecutive clocks.
module key_debounce_bit
   import key_debounce_filter_pkg::*;
#(
   parameter int unsigned DB_CYCLES = KDF_DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_db
);

   localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

   logic           sync_meta;
   logic           sync_q;
   logic [DBW-1:0] cnt;

   // Two-stage synchroniser for the asynchronous raw level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= key_raw;
         sync_q    <= sync_meta;
      end
   end

   // Hold counter: any return to the accepted level restarts the count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         key_db <= 1'b0;
      end else if (sync_q == key_db) begin
         cnt <= '0;
      end else if (cnt == DB_LAST) begin
         key_db <= sync_q;
         cnt    <= '0;
      end else begin
         cnt <= cnt + DBW'(1);
      end
   end

endmodule

// File: rtl/key_debounce_filter.sv
// Raw key vector cleaner: per-key synchronise + debounce, then a whole-vector
// settle filter so partial chords and bounce never reach key_vec. Publishes
// the clean vector with its popcount and one-cycle press/release strobes.
module key_debounce_filter
   import key_debounce_filter_pkg::*;
#(
   parameter int unsigned KEYS          = KDF_KEYS,
   parameter int unsigned DB_CYCLES     = KDF_DB_CYCLES,
   parameter int unsigned SETTLE_CYCLES = KDF_SETTLE_CYCLES,
   localparam int unsigned CW           = $clog2(KEYS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [KEYS-1:0] key_raw,
   output logic [KEYS-1:0] key_vec,
   output logic            press_pulse,
   output logic            release_pulse,
   output logic [CW-1:0]   key_cnt,
   output logic            settling
);

   localparam int unsigned STW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [STW-1:0] ST_LAST = STW'(SETTLE_CYCLES - 1);

   logic [KEYS-1:0] db;
   logic [KEYS-1:0] cand;
   logic [STW-1:0]  st_cnt;
   kdf_state_t      state;

   for (genvar g = 0; g < KEYS; g++) begin : g_key
      key_debounce_bit #(
         .DB_CYCLES (DB_CYCLES)
      ) u_bit (
         .clk     (clk),
         .rst     (rst),
         .key_raw (key_raw[g]),
         .key_db  (db[g])
      );
   end

   // Settle FSM: time a candidate vector, publish it once it holds long enough.
   // settling is registered alongside every state transition so it always
   // equals (state == KDF_SETTLE).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= KDF_STABLE;
         cand          <= '0;
         st_cnt        <= '0;
         key_vec       <= '0;
         key_cnt       <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         settling      <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         case (state)
            KDF_STABLE: begin
               if (db != key_vec) begin
                  cand     <= db;
                  st_cnt   <= '0;
                  state    <= KDF_SETTLE;
                  settling <= 1'b1;
               end
            end
            KDF_SETTLE: begin
               if (db == key_vec) begin
                  // bounced back to the published value: drop the candidate
                  state    <= KDF_STABLE;
                  settling <= 1'b0;
               end else if (db != cand) begin
                  // chord still forming: restart timing on the new shape
                  cand   <= db;
                  st_cnt <= '0;
               end else if (st_cnt == ST_LAST) begin
                  key_vec       <= cand;
                  key_cnt       <= CW'(kdf_popcount(32'(cand)));
                  press_pulse   <= (cand != '0);
                  release_pulse <= (cand == '0);
                  state         <= KDF_STABLE;
                  settling      <= 1'b0;
               end else begin
                  st_cnt <= st_cnt + STW'(1);
               end
            end
            default: begin
               state    <= KDF_STABLE;
               settling <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_debounce_filter.sv
// Directed bench for key_debounce_filter with DB_CYCLES=4, SETTLE_CYCLES=8
// (raw step to key_vec update = 2 + 4 + 1 + 8 = 15 clock edges).
module tb_key_debounce_filter;

   logic       clk;
   logic       rst;
   logic [9:0] key_raw;
   logic [9:0] key_vec;
   logic       press_pulse;
   logic       release_pulse;
   logic [3:0] key_cnt;
   logic       settling;

   int         checks;
   int         errors;

   // event monitor state
   int         n_press;
   int         n_release;
   int         n_both;
   int         n_change;
   logic       saw_settle;
   logic [9:0] prev_vec;
   logic       found;

   key_debounce_filter #(
      .KEYS          (10),
      .DB_CYCLES     (4),
      .SETTLE_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .key_raw       (key_raw),
      .key_vec       (key_vec),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .key_cnt       (key_cnt),
      .settling      (settling)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count strobes and key_vec changes, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         if (press_pulse) n_press++;
         if (release_pulse) n_release++;
         if (press_pulse && release_pulse) n_both++;
         if (key_vec != prev_vec) n_change++;
         if (settling) saw_settle = 1'b1;
         prev_vec = key_vec;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // n active edges, then settle 1 time unit past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      n_press    = 0;
      n_release  = 0;
      n_both     = 0;
      n_change   = 0;
      saw_settle = 1'b0;
      prev_vec   = key_vec;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b0;
      key_raw = 10'h3FF;
      clear_mon();

      // 1: reset holds everything at zero, then full-latency publish
      tick(3);
      check("rst_vec", key_vec, 0);
      check("rst_cnt", key_cnt, 0);
      check("rst_press", press_pulse, 0);
      check("rst_release", release_pulse, 0);
      check("rst_settling", settling, 0);
      rst = 1'b1;
      clear_mon();
      tick(14);
      check("t1_vec_e14", key_vec, 0);
      tick(1);
      check("t1_vec_e15", key_vec, 10'h3FF);
      check("t1_cnt", key_cnt, 10);
      check("t1_press", press_pulse, 1);
      check("t1_release", release_pulse, 0);
      tick(1);
      check("t1_press_drop", press_pulse, 0);
      tick(10);
      check("t1_n_press", n_press, 1);
      check("t1_n_change", n_change, 1);
      key_raw = 10'h000;
      tick(15);
      check("t1_idle_vec", key_vec, 0);
      check("t1_idle_release", release_pulse, 1);
      tick(5);

      // 2: a 3-clock glitch is shorter than the debounce hold
      clear_mon();
      key_raw = 10'h008;
      tick(3);
      key_raw = 10'h000;
      tick(30);
      check("t2_vec", key_vec, 0);
      check("t2_n_press", n_press, 0);
      check("t2_n_release", n_release, 0);
      check("t2_saw_settle", saw_settle, 0);

      // 3: single key press then release
      clear_mon();
      key_raw = 10'h004;
      tick(14);
      check("t3_vec_e14", key_vec, 0);
      tick(1);
      check("t3_vec", key_vec, 10'h004);
      check("t3_cnt", key_cnt, 1);
      check("t3_press", press_pulse, 1);
      tick(25);
      check("t3_n_press", n_press, 1);
      key_raw = 10'h000;
      tick(14);
      check("t3_rel_e14", key_vec, 10'h004);
      tick(1);
      check("t3_rel_vec", key_vec, 0);
      check("t3_rel_pulse", release_pulse, 1);
      check("t3_rel_nopress", press_pulse, 0);
      check("t3_rel_cnt", key_cnt, 0);
      tick(1);
      check("t3_rel_drop", release_pulse, 0);
      check("t3_n_release", n_release, 1);
      check("t3_n_both", n_both, 0);
      tick(5);

      // 4: staggered chord publishes once, no intermediate 001
      clear_mon();
      key_raw = 10'h001;
      tick(6);
      key_raw = 10'h021;
      tick(14);
      check("t4_vec_e20", key_vec, 0);
      tick(1);
      check("t4_vec", key_vec, 10'h021);
      check("t4_cnt", key_cnt, 2);
      check("t4_press", press_pulse, 1);
      tick(10);
      check("t4_n_change", n_change, 1);
      check("t4_n_press", n_press, 1);
      check("t4_n_release", n_release, 0);

      // 4b: nonzero to different nonzero chord is a press
      key_raw = 10'h004;
      tick(14);
      check("t4b_vec_e14", key_vec, 10'h021);
      tick(1);
      check("t4b_vec", key_vec, 10'h004);
      check("t4b_press", press_pulse, 1);
      check("t4b_release", release_pulse, 0);
      check("t4b_cnt", key_cnt, 1);
      tick(5);

      // 5: bounce back to the published value leaves outputs untouched
      clear_mon();
      key_raw = 10'h000;
      tick(8);
      key_raw = 10'h004;
      tick(30);
      check("t5_vec", key_vec, 10'h004);
      check("t5_n_press", n_press, 0);
      check("t5_n_release", n_release, 0);
      check("t5_n_change", n_change, 0);
      check("t5_saw_settle", saw_settle, 1);
      check("t5_settling_end", settling, 0);

      // 6: asynchronous reset while settling discards the candidate
      clear_mon();
      key_raw = 10'h3C0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick(1);
         if (settling) found = 1'b1;
      end
      check("t6_reach_settle", found, 1);
      #2 rst = 1'b0;
      #1;
      check("t6_async_vec", key_vec, 0);
      check("t6_async_cnt", key_cnt, 0);
      check("t6_async_settling", settling, 0);
      check("t6_async_press", press_pulse, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      clear_mon();
      tick(14);
      check("t6_vec_e14", key_vec, 0);
      tick(1);
      check("t6_vec", key_vec, 10'h3C0);
      check("t6_cnt", key_cnt, 4);
      check("t6_press", press_pulse, 1);
      tick(3);
      check("t6_n_press", n_press, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
